// File: rtl/exu_pkg.sv
// Shared exu load/store types: request payload and arbiter FSM state encoding.
package exu_pkg;

  localparam int unsigned LDST_ADDR_W = 32;
  localparam int unsigned LDST_DATA_W = 32;
  localparam int unsigned LDST_STRB_W = LDST_DATA_W / 8;

  typedef struct packed {
    logic [LDST_ADDR_W-1:0] addr;
    logic                   wen;
    logic [LDST_DATA_W-1:0] wdata;
    logic [LDST_STRB_W-1:0] strb;
  } ldst_req_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/exu_ldst_ord_fifo.sv
// Order FIFO of issuing requester indices; responses return in request order.
module exu_ldst_ord_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/exu_ldst_arb.sv
// Load/store arbiter: REQ_NUM requesters onto one ldst port, in-order response routing.
// Build option EXU_LDST_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module exu_ldst_arb
  import exu_pkg::*;
#(
  parameter int unsigned REQ_NUM   = 2,
  parameter int unsigned OST_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [REQ_NUM-1:0]             s_req_vld,
  output logic [REQ_NUM-1:0]             s_req_rdy,
  input  logic [REQ_NUM*LDST_ADDR_W-1:0] s_req_addr,
  input  logic [REQ_NUM-1:0]             s_req_wen,
  input  logic [REQ_NUM*LDST_DATA_W-1:0] s_req_wdata,
  input  logic [REQ_NUM*LDST_STRB_W-1:0] s_req_strb,
  output logic [REQ_NUM-1:0]             s_rsp_vld,
  output logic [LDST_DATA_W-1:0]         s_rsp_rdata,
  output logic                           m_req_vld,
  input  logic                           m_req_rdy,
  output logic [LDST_ADDR_W-1:0]         m_req_addr,
  output logic                           m_req_wen,
  output logic [LDST_DATA_W-1:0]         m_req_wdata,
  output logic [LDST_STRB_W-1:0]         m_req_strb,
  input  logic                           m_rsp_vld,
  input  logic [LDST_DATA_W-1:0]         m_rsp_rdata
);

  localparam int unsigned IDX_W = $clog2(REQ_NUM);

  ldst_req_t        req [REQ_NUM];
  ldst_req_t        sel;
  arb_state_e       state_q;
  arb_state_e       state_nxt;
  logic [IDX_W-1:0] lock_idx_q;
  logic [IDX_W-1:0] rr_base;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] fifo_head;
  logic             pick_vld;
  logic             grant_vld;
  logic             req_hs;
  logic             rsp_pop;
  logic             ost_full;
  logic             fifo_empty;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                               input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= REQ_NUM) s = s - REQ_NUM;
    return IDX_W'(s);
  endfunction

  for (genvar g = 0; g < int'(REQ_NUM); g++) begin : g_unpack
    assign req[g] = '{addr:  s_req_addr[g*LDST_ADDR_W +: LDST_ADDR_W],
                      wen:   s_req_wen[g],
                      wdata: s_req_wdata[g*LDST_DATA_W +: LDST_DATA_W],
                      strb:  s_req_strb[g*LDST_STRB_W +: LDST_STRB_W]};
  end

`ifdef EXU_LDST_ARB_FIXED_PRIO_EN
  assign rr_base = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q;

  // Next search starts just past the last winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr_q <= '0;
    else if (req_hs) rr_ptr_q <= rr_idx(win_idx, 1);
  end

  assign rr_base = rr_ptr_q;
`endif

  always_comb begin : pick_search
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      if (!pick_vld && s_req_vld[rr_idx(rr_base, k)]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx(rr_base, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin : fsm_next
    state_nxt = state_q;
    case (state_q)
      ARB_IDLE: if (pick_vld && !ost_full && !m_req_rdy) state_nxt = ARB_LOCK;
      ARB_LOCK: if (m_req_rdy) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // Full blocks new grants even when a pop lands this cycle: no rsp->req path.
  always_comb begin : fsm_out
    grant_vld = 1'b0;
    win_idx   = pick_idx;
    case (state_q)
      ARB_IDLE: grant_vld = pick_vld && !ost_full;
      ARB_LOCK: begin
        grant_vld = 1'b1;
        win_idx   = lock_idx_q;
      end
      default: grant_vld = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          lock_idx_q <= '0;
    else if (state_q == ARB_IDLE && state_nxt == ARB_LOCK) lock_idx_q <= pick_idx;
  end

  assign m_req_vld   = grant_vld & rst_n;
  assign req_hs      = m_req_vld & m_req_rdy & ~ost_full;
  assign sel         = m_req_vld ? req[win_idx] : '0;
  assign m_req_addr  = sel.addr;
  assign m_req_wen   = sel.wen;
  assign m_req_wdata = sel.wdata;
  assign m_req_strb  = sel.strb;

  always_comb begin : req_ready
    s_req_rdy = '0;
    if (req_hs) s_req_rdy[win_idx] = 1'b1;
  end

  // A response with nothing outstanding is dropped.
  assign rsp_pop     = m_rsp_vld & ~fifo_empty;
  assign s_rsp_rdata = rsp_pop ? m_rsp_rdata : '0;

  always_comb begin : rsp_route
    s_rsp_vld = '0;
    if (rsp_pop) s_rsp_vld[fifo_head] = 1'b1;
  end

  exu_ldst_ord_fifo #(
    .DEPTH (OST_DEPTH),
    .WIDTH (IDX_W)
  ) u_ord_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_hs),
    .push_data (win_idx),
    .pop       (m_rsp_vld),
    .full      (ost_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  a_rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
                                    m_rsp_vld |-> !fifo_empty)
    else $error("exu_ldst_arb: response received with no outstanding request");

endmodule

// File: tb/tb_exu_ldst_arb.sv
// Directed bench for exu_ldst_arb with a queue-based reference model checked every cycle.
module tb_exu_ldst_arb;

  localparam int NREQ = 2;
  localparam int OST  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   s_req_vld;
  logic [NREQ-1:0]   s_req_rdy;
  logic [NREQ*32-1:0] s_req_addr;
  logic [NREQ-1:0]   s_req_wen;
  logic [NREQ*32-1:0] s_req_wdata;
  logic [NREQ*4-1:0] s_req_strb;
  logic [NREQ-1:0]   s_rsp_vld;
  logic [31:0]       s_rsp_rdata;
  logic              m_req_vld;
  logic              m_req_rdy;
  logic [31:0]       m_req_addr;
  logic              m_req_wen;
  logic [31:0]       m_req_wdata;
  logic [3:0]        m_req_strb;
  logic              m_rsp_vld;
  logic [31:0]       m_rsp_rdata;

  int checks = 0;
  int errors = 0;

  exu_ldst_arb #(.REQ_NUM(NREQ), .OST_DEPTH(OST)) dut (
    .clk (clk), .rst_n (rst_n),
    .s_req_vld (s_req_vld), .s_req_rdy (s_req_rdy), .s_req_addr (s_req_addr),
    .s_req_wen (s_req_wen), .s_req_wdata (s_req_wdata), .s_req_strb (s_req_strb),
    .s_rsp_vld (s_rsp_vld), .s_rsp_rdata (s_rsp_rdata),
    .m_req_vld (m_req_vld), .m_req_rdy (m_req_rdy), .m_req_addr (m_req_addr),
    .m_req_wen (m_req_wen), .m_req_wdata (m_req_wdata), .m_req_strb (m_req_strb),
    .m_rsp_vld (m_rsp_vld), .m_rsp_rdata (m_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
    s_req_vld[i]          = v;
    s_req_addr[i*32 +: 32] = a;
    s_req_wen[i]          = w;
    s_req_wdata[i*32 +: 32] = d;
    s_req_strb[i*4 +: 4]   = s;
  endtask

  // Reference model: issue-order queue, round-robin pointer, pending (locked) requester.
  int q[$];
  int rr   = 0;
  int lock = -1;

  always @(negedge clk) begin : cmp
    bit          evld;
    int          win;
    logic [1:0]  erdy;
    logic [1:0]  ersp;
    logic [31:0] erd;
    logic [31:0] eaddr;
    logic [36:0] eside;
    if (!rst_n) begin
      check("rst_m_req_vld", 64'(m_req_vld), 64'd0);
      check("rst_s_req_rdy", 64'(s_req_rdy), 64'd0);
      check("rst_s_rsp_vld", 64'(s_rsp_vld), 64'd0);
      q.delete();
      rr   = 0;
      lock = -1;
    end else begin
      evld = 1'b0;
      win  = 0;
      if (lock >= 0) begin
        evld = 1'b1;
        win  = lock;
      end else if (q.size() < OST) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!evld && s_req_vld[(rr + i) % NREQ]) begin
            evld = 1'b1;
            win  = (rr + i) % NREQ;
          end
        end
      end
      erdy  = (evld && m_req_rdy) ? 2'(1 << win) : 2'b00;
      eaddr = evld ? s_req_addr[win*32 +: 32] : 32'd0;
      eside = evld ? {s_req_wen[win], s_req_strb[win*4 +: 4], s_req_wdata[win*32 +: 32]} : 37'd0;
      ersp  = (m_rsp_vld && q.size() > 0) ? 2'(1 << q[0]) : 2'b00;
      erd   = (m_rsp_vld && q.size() > 0) ? m_rsp_rdata : 32'd0;
      check("mdl_m_req_vld", 64'(m_req_vld), 64'(evld));
      check("mdl_s_req_rdy", 64'(s_req_rdy), 64'(erdy));
      check("mdl_m_req_addr", 64'(m_req_addr), 64'(eaddr));
      check("mdl_m_req_side", 64'({m_req_wen, m_req_strb, m_req_wdata}), 64'(eside));
      check("mdl_s_rsp_vld", 64'(s_rsp_vld), 64'(ersp));
      check("mdl_s_rsp_rdata", 64'(s_rsp_rdata), 64'(erd));
      if (m_rsp_vld && q.size() > 0) void'(q.pop_front());
      if (evld && m_req_rdy) begin
        q.push_back(win);
`ifndef EXU_LDST_ARB_FIXED_PRIO_EN
        rr = (win + 1) % NREQ;
`endif
        lock = -1;
      end else if (evld) begin
        lock = win;
      end
    end
  end

`ifdef EXU_LDST_ARB_FIXED_PRIO_EN
  logic [1:0] exp_gnt [4] = '{2'b01, 2'b01, 2'b01, 2'b01};
  logic [1:0] exp_rsp [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`else
  logic [1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] exp_rsp [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif

  initial begin
    rst_n = 1'b0;
    s_req_vld = '0; s_req_addr = '0; s_req_wen = '0; s_req_wdata = '0; s_req_strb = '0;
    m_req_rdy = 1'b0; m_rsp_vld = 1'b0; m_rsp_rdata = '0;
    repeat (3) tick();
    check("reset_m_req_addr", 64'(m_req_addr), 64'd0);
    rst_n = 1'b1;

    // Single requester 0 load, response one cycle later.
    set_req(0, 1'b1, 32'h100, 1'b0, 32'h0, 4'h0);
    m_req_rdy = 1'b1;
    probe();
    check("t1_s_req_rdy", 64'(s_req_rdy), 64'h1);
    check("t1_m_req_addr", 64'(m_req_addr), 64'h100);
    tick();
    set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    m_rsp_vld = 1'b1; m_rsp_rdata = 32'hDEADBEEF;
    probe();
    check("t1_s_rsp_vld", 64'(s_rsp_vld), 64'h1);
    check("t1_s_rsp_rdata", 64'(s_rsp_rdata), 64'hDEADBEEF);
    tick();
    m_rsp_vld = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Both requesters continuously valid: alternating grants fill the order FIFO.
    set_req(0, 1'b1, 32'h1000, 1'b0, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h2000, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      probe();
      check($sformatf("t2_grant%0d", k), 64'(s_req_rdy), 64'(exp_gnt[k]));
      tick();
    end
    // FIFO full: fifth request stalls, also in the cycle a response pops.
    set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    probe();
    check("t4_stall_full", 64'(m_req_vld), 64'd0);
    tick();
    m_rsp_vld = 1'b1; m_rsp_rdata = 32'h11;
    probe();
    check("t4_stall_on_pop", 64'(m_req_vld), 64'd0);
    check("t2_rsp0", 64'(s_rsp_vld), 64'(exp_rsp[0]));
    tick();
    m_rsp_rdata = 32'h22;
    probe();
    check("t4_issue_after_pop", 64'(s_req_rdy), 64'h1);
    check("t2_rsp1", 64'(s_rsp_vld), 64'(exp_rsp[1]));
    tick();
    set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    for (int k = 2; k < 5; k++) begin
      m_rsp_rdata = 32'(k * 16'h0101);
      probe();
      check($sformatf("t2_rsp%0d", k), 64'(s_rsp_vld), 64'(exp_rsp[k]));
      tick();
    end
    m_rsp_vld = 1'b0;

    // Backpressure: requester 1 locked while requester 0 waits.
    set_req(1, 1'b1, 32'h200, 1'b1, 32'hCAFEF00D, 4'hF);
    m_req_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      probe();
      check($sformatf("t3_lock_addr%0d", k), 64'(m_req_addr), 64'h200);
      check($sformatf("t3_lock_rdy%0d", k), 64'(s_req_rdy), 64'h0);
      tick();
      set_req(0, 1'b1, 32'h300, 1'b0, 32'h0, 4'h0);
    end
    m_req_rdy = 1'b1;
    probe();
    check("t3_gnt1_rdy", 64'(s_req_rdy), 64'h2);
    check("t3_gnt1_wdata", 64'(m_req_wdata), 64'hCAFEF00D);
    tick();
    probe();
    check("t3_gnt0_rdy", 64'(s_req_rdy), 64'h1);
    check("t3_gnt0_addr", 64'(m_req_addr), 64'h300);
    tick();

    // Reset with two outstanding while both requesters are valid.
    set_req(1, 1'b1, 32'h2000, 1'b0, 32'h0, 4'h0);
    set_req(0, 1'b1, 32'h1000, 1'b0, 32'h0, 4'h0);
    m_rsp_vld = 1'b1; m_rsp_rdata = 32'h55;
    rst_n = 1'b0;
    #1;
    check("t5_m_req_vld", 64'(m_req_vld), 64'd0);
    check("t5_s_req_rdy", 64'(s_req_rdy), 64'd0);
    check("t5_m_req_addr", 64'(m_req_addr), 64'd0);
    check("t5_s_rsp_vld", 64'(s_rsp_vld), 64'd0);
    check("t5_s_rsp_rdata", 64'(s_rsp_rdata), 64'd0);
    tick();
    tick();
    m_rsp_vld = 1'b0;
    rst_n = 1'b1;
    // After release: arbitration restarts at requester 0 with an empty FIFO.
    for (int k = 0; k < 4; k++) begin
      probe();
      check($sformatf("t6_grant%0d", k), 64'(s_req_rdy), 64'(exp_gnt[k]));
      tick();
    end
    probe();
    check("t5_full_after_four", 64'(m_req_vld), 64'd0);
    tick();
    set_req(0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    m_rsp_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_rsp_rdata = 32'hA0 + 32'(k);
      probe();
      check($sformatf("t6_rsp%0d", k), 64'(s_rsp_vld), 64'(exp_gnt[k]));
      tick();
    end
    m_rsp_vld = 1'b0;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
